// File: rtl/sensor_caixa_pkg.sv
// rtl/sensor_caixa_pkg.sv - shared FSM states and valid level patterns for the tank sensor filter
`timescale 1ns/1ps
package sensor_caixa_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SUSPEITO = 2'd1,
    ERRO     = 2'd2,
    RECUPERA = 2'd3
  } estado_t;

  localparam logic [2:0] NIVEL_VAZIO = 3'b000;
  localparam logic [2:0] NIVEL_BAIXO = 3'b001;
  localparam logic [2:0] NIVEL_MEDIO = 3'b011;
  localparam logic [2:0] NIVEL_ALTO  = 3'b111;

  // An upper switch wet while a lower one is dry is physically impossible.
  function automatic logic padrao_valido(input logic [2:0] p);
    return (p == NIVEL_VAZIO) || (p == NIVEL_BAIXO) ||
           (p == NIVEL_MEDIO) || (p == NIVEL_ALTO);
  endfunction

endpackage

// File: rtl/filtro_sensor.sv
// rtl/filtro_sensor.sv - two-flop synchroniser plus debounce counter for one float switch
`timescale 1ns/1ps
module filtro_sensor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_nivel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_nivel;

  // The count-th differing sample is the one that flips the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_nivel <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_nivel) begin
        if (r_cnt == CNT_FIM) begin
          r_nivel <= ~r_nivel;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_nivel = r_nivel;

endmodule

// File: rtl/sensor_caixa_filtro.sv
// rtl/sensor_caixa_filtro.sv - conditions the three float switches into Alta/Media/Baixa
// and raises a persistent Erro flag on inconsistent level patterns.
`timescale 1ns/1ps
module sensor_caixa_filtro
  import sensor_caixa_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ERRO_CYCLES     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_alta,
  input  logic sensor_media,
  input  logic sensor_baixa,
  output logic Alta,
  output logic Media,
  output logic Baixa,
  output logic Erro,
  output logic nivel_mudou
);

  localparam int EW = $clog2(ERRO_CYCLES + 1);
  localparam logic [EW-1:0] CNT_FIM = EW'(ERRO_CYCLES - 1);
  localparam logic [EW-1:0] CNT_UM  = EW'(1);

  estado_t       r_estado;
  estado_t       w_estado_prox;
  logic [EW-1:0] r_cnt;
  logic [EW-1:0] w_cnt_prox;
  logic [2:0]    r_p_prev;
  logic          r_mudou;
  logic [2:0]    w_p;
  logic          w_valido;

  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alta (
    .clk(clk), .rst(rst), .i_raw(sensor_alta), .o_nivel(Alta));
  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_media (
    .clk(clk), .rst(rst), .i_raw(sensor_media), .o_nivel(Media));
  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_baixa (
    .clk(clk), .rst(rst), .i_raw(sensor_baixa), .o_nivel(Baixa));

  assign w_p      = {Alta, Media, Baixa};
  assign w_valido = padrao_valido(w_p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= NORMAL;
      r_cnt    <= '0;
      r_p_prev <= NIVEL_VAZIO;
      r_mudou  <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      r_p_prev <= w_p;
      r_mudou  <= (w_p != r_p_prev);
    end
  end

  // Entering SUSPEITO/RECUPERA already counts the first cycle, hence CNT_UM.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    case (r_estado)
      NORMAL: if (!w_valido) begin
        if (ERRO_CYCLES <= 1) begin
          w_estado_prox = ERRO;
          w_cnt_prox    = '0;
        end else begin
          w_estado_prox = SUSPEITO;
          w_cnt_prox    = CNT_UM;
        end
      end
      SUSPEITO: if (w_valido) begin
        w_estado_prox = NORMAL;
        w_cnt_prox    = '0;
      end else if (r_cnt == CNT_FIM) begin
        w_estado_prox = ERRO;
        w_cnt_prox    = '0;
      end else begin
        w_cnt_prox = r_cnt + 1'b1;
      end
      ERRO: if (w_valido) begin
        if (ERRO_CYCLES <= 1) begin
          w_estado_prox = NORMAL;
          w_cnt_prox    = '0;
        end else begin
          w_estado_prox = RECUPERA;
          w_cnt_prox    = CNT_UM;
        end
      end
      RECUPERA: if (!w_valido) begin
        w_estado_prox = ERRO;
        w_cnt_prox    = '0;
      end else if (r_cnt == CNT_FIM) begin
        w_estado_prox = NORMAL;
        w_cnt_prox    = '0;
      end else begin
        w_cnt_prox = r_cnt + 1'b1;
      end
      default: begin
        w_estado_prox = NORMAL;
        w_cnt_prox    = '0;
      end
    endcase
  end

  assign Erro        = (r_estado == ERRO) || (r_estado == RECUPERA);
  assign nivel_mudou = r_mudou;

endmodule

// File: tb/tb_sensor_caixa_filtro.sv
// tb/tb_sensor_caixa_filtro.sv - directed self-checking bench for sensor_caixa_filtro
`timescale 1ns/1ps
module tb_sensor_caixa_filtro;
  import sensor_caixa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_alta = 1'b0;
  logic sensor_media = 1'b0;
  logic sensor_baixa = 1'b0;
  logic Alta, Media, Baixa, Erro, nivel_mudou;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int erro_alto = 0;
  int erro_baixo = 0;
  int media_alta = 0;

  sensor_caixa_filtro #(.DEBOUNCE_CYCLES(4), .ERRO_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .sensor_alta(sensor_alta), .sensor_media(sensor_media), .sensor_baixa(sensor_baixa),
    .Alta(Alta), .Media(Media), .Baixa(Baixa), .Erro(Erro), .nivel_mudou(nivel_mudou));

  always #5 clk = ~clk;

  wire [2:0] P = {Alta, Media, Baixa};

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (nivel_mudou) pulses++;
      if (Erro) erro_alto++; else erro_baixo++;
      if (Media) media_alta++;
    end
  endtask

  task automatic set_raw(input logic [2:0] v);
    {sensor_alta, sensor_media, sensor_baixa} = v;
  endtask

  task automatic test_reset;
    step(2);
    checks++; if ({P, Erro, nivel_mudou} !== 5'b0) begin errors++; $display("FAIL reset_hold got=%b exp=00000", {P, Erro, nivel_mudou}); end
    rst = 1'b0;
    set_raw(3'b111);
    step(10);
    checks++; if (P !== 3'b111) begin errors++; $display("FAIL reset_prefill got=%b exp=111", P); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (P !== 3'b000) begin errors++; $display("FAIL reset_async_p got=%b exp=000", P); end
    checks++; if (Erro !== 1'b0) begin errors++; $display("FAIL reset_async_erro got=%b exp=0", Erro); end
    checks++; if (nivel_mudou !== 1'b0) begin errors++; $display("FAIL reset_async_pulse got=%b exp=0", nivel_mudou); end
    checks++; if (dut.r_estado !== NORMAL) begin errors++; $display("FAIL reset_async_state got=%0d exp=0", dut.r_estado); end
    set_raw(3'b000);
    step(2);
    rst = 1'b0;
    pulses = 0;
    step(10);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_exit_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_fill;
    pulses = 0; erro_alto = 0;
    sensor_baixa = 1'b1;
    step(5);
    checks++; if (Baixa !== 1'b0) begin errors++; $display("FAIL fill_latency_early got=%b exp=0", Baixa); end
    step(1);
    checks++; if (Baixa !== 1'b1) begin errors++; $display("FAIL fill_latency_edge6 got=%b exp=1", Baixa); end
    step(14);
    checks++; if (P !== 3'b001) begin errors++; $display("FAIL fill_p001 got=%b exp=001", P); end
    sensor_media = 1'b1;
    step(20);
    checks++; if (P !== 3'b011) begin errors++; $display("FAIL fill_p011 got=%b exp=011", P); end
    sensor_alta = 1'b1;
    step(20);
    checks++; if (P !== 3'b111) begin errors++; $display("FAIL fill_p111 got=%b exp=111", P); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL fill_pulses got=%0d exp=3", pulses); end
    checks++; if (erro_alto !== 0) begin errors++; $display("FAIL fill_erro got=%0d cycles exp=0", erro_alto); end
  endtask

  task automatic test_glitch;
    set_raw(3'b001);
    step(20);
    checks++; if (P !== 3'b001) begin errors++; $display("FAIL glitch_start got=%b exp=001", P); end
    pulses = 0; media_alta = 0;
    sensor_media = 1'b1; step(1); sensor_media = 1'b0; step(10);
    sensor_media = 1'b1; step(3); sensor_media = 1'b0; step(10);
    checks++; if (media_alta !== 0) begin errors++; $display("FAIL glitch_media got=%0d cycles exp=0", media_alta); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_short_inconsistency;
    set_raw(3'b000);
    step(20);
    erro_alto = 0;
    sensor_alta = 1'b1;
    step(5);
    sensor_alta = 1'b0;
    step(2);
    checks++; if (dut.r_estado !== SUSPEITO) begin errors++; $display("FAIL short_suspeito got=%0d exp=1", dut.r_estado); end
    step(20);
    checks++; if (dut.r_estado !== NORMAL) begin errors++; $display("FAIL short_normal got=%0d exp=0", dut.r_estado); end
    checks++; if (erro_alto !== 0) begin errors++; $display("FAIL short_erro got=%0d cycles exp=0", erro_alto); end
  endtask

  task automatic test_fault_recovery;
    sensor_alta = 1'b1; step(8);
    sensor_alta = 1'b0; step(4);
    sensor_alta = 1'b1; step(1);
    checks++; if (Erro !== 1'b0) begin errors++; $display("FAIL fault_before8 got=%b exp=0", Erro); end
    step(1);
    checks++; if (Erro !== 1'b1) begin errors++; $display("FAIL fault_at8 got=%b exp=1", Erro); end
    erro_baixo = 0;
    step(2);
    sensor_alta = 1'b0;
    step(2);
    checks++; if (dut.r_estado !== RECUPERA) begin errors++; $display("FAIL fault_recupera got=%0d exp=3", dut.r_estado); end
    step(11);
    checks++; if (Erro !== 1'b1) begin errors++; $display("FAIL fault_valid7 got=%b exp=1", Erro); end
    checks++; if (erro_baixo !== 0) begin errors++; $display("FAIL fault_held got=%0d low cycles exp=0", erro_baixo); end
    step(1);
    checks++; if (Erro !== 1'b0) begin errors++; $display("FAIL fault_valid8 got=%b exp=0", Erro); end
  endtask

  task automatic test_invalid_to_invalid;
    step(10);
    pulses = 0;
    sensor_alta = 1'b1; step(4);
    sensor_media = 1'b1; step(4);
    set_raw(3'b000); step(5);
    checks++; if (Erro !== 1'b0) begin errors++; $display("FAIL inv_before8 got=%b exp=0", Erro); end
    step(1);
    checks++; if (Erro !== 1'b1) begin errors++; $display("FAIL inv_at8 got=%b exp=1", Erro); end
    step(16);
    checks++; if (Erro !== 1'b0) begin errors++; $display("FAIL inv_recovered got=%b exp=0", Erro); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL inv_pulses got=%0d exp=3", pulses); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_glitch;
    test_short_inconsistency;
    test_fault_recovery;
    test_invalid_to_invalid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
